// File: rtl/btn_pio_pkg.sv
// btn_pio_pkg: edge-mode encodings, register map and sizing helper for the button PIO
package btn_pio_pkg;

    localparam int EDGE_RISE = 0;
    localparam int EDGE_FALL = 1;
    localparam int EDGE_ANY  = 2;

    localparam logic [1:0] ADDR_DATA    = 2'd0;
    localparam logic [1:0] ADDR_RSVD    = 2'd1;
    localparam logic [1:0] ADDR_IRQMASK = 2'd2;
    localparam logic [1:0] ADDR_EDGECAP = 2'd3;

    // Counter only ever holds 0..cycles-1, so clog2 bits suffice (min 1)
    function automatic int cnt_width(input int cycles);
        return (cycles > 1) ? $clog2(cycles) : 1;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// btn_debounce: one channel of 2-flop synchronizer plus stability-count debouncer
module btn_debounce
    import btn_pio_pkg::*;
#(
    parameter int   DEBOUNCE_CYCLES = 4,
    parameter logic IDLE            = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic i_pin,
    output logic o_db,
    output logic o_rise,
    output logic o_fall
);

    localparam int            CW   = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          r_s1;
    logic          r_s2;
    logic          r_db;
    logic [CW-1:0] r_cnt;
    logic          w_diff;
    logic          w_accept;

    assign w_diff   = r_s2 != r_db;
    assign w_accept = w_diff && (r_cnt == LAST);

    // Synchronize the pin, then accept its level once it has differed for DEBOUNCE_CYCLES samples
    always_ff @(posedge clk) begin
        if (reset) begin
            r_s1  <= IDLE;
            r_s2  <= IDLE;
            r_db  <= IDLE;
            r_cnt <= '0;
        end else begin
            r_s1  <= i_pin;
            r_s2  <= r_s1;
            r_db  <= w_accept ? r_s2 : r_db;
            r_cnt <= (w_diff && !w_accept) ? r_cnt + CW'(1) : '0;
        end
    end

    assign o_db   = r_db;
    assign o_rise = w_accept & r_s2;
    assign o_fall = w_accept & ~r_s2;

endmodule

// File: rtl/btn_pio_edge.sv
// btn_pio_edge: debounced button PIO with edge capture, irq mask and Avalon-MM register access
module btn_pio_edge
    import btn_pio_pkg::*;
#(
    parameter int               WIDTH           = 2,
    parameter int               DEBOUNCE_CYCLES = 4,
    parameter int               EDGE_MODE       = 0,
    parameter logic [WIDTH-1:0] IDLE_LEVEL      = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    input  logic [WIDTH-1:0] in_port,
    output logic [31:0]      readdata,
    output logic             irq
);

    logic [WIDTH-1:0] w_db;
    logic [WIDTH-1:0] w_rise;
    logic [WIDTH-1:0] w_fall;
    logic [WIDTH-1:0] w_set;
    logic [WIDTH-1:0] w_clr;
    logic [WIDTH-1:0] r_mask;
    logic [WIDTH-1:0] r_ecap;
    logic [31:0]      r_rdata;
    logic [31:0]      w_rdata;
    logic             w_wr;
    logic             w_unused;

    for (genvar i = 0; i < WIDTH; i++) begin : g_ch
        btn_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .IDLE           (IDLE_LEVEL[i])
        ) u_deb (
            .clk   (clk),
            .reset (reset),
            .i_pin (in_port[i]),
            .o_db  (w_db[i]),
            .o_rise(w_rise[i]),
            .o_fall(w_fall[i])
        );
    end

    assign w_wr     = chipselect && !write_n;
    assign w_set    = (EDGE_MODE == EDGE_RISE) ? w_rise :
                      (EDGE_MODE == EDGE_FALL) ? w_fall : (w_rise | w_fall);
    assign w_clr    = (w_wr && address == ADDR_EDGECAP) ? writedata[WIDTH-1:0] : '0;
    assign w_rdata  = (address == ADDR_DATA)    ? 32'(w_db)   :
                      (address == ADDR_IRQMASK) ? 32'(r_mask) :
                      (address == ADDR_EDGECAP) ? 32'(r_ecap) : '0;
    assign w_unused = ^writedata;

    // Mask and capture registers; a new capture overrides a same-cycle clear
    always_ff @(posedge clk) begin
        if (reset) begin
            r_mask <= '0;
            r_ecap <= '0;
        end else begin
            r_mask <= (w_wr && address == ADDR_IRQMASK) ? writedata[WIDTH-1:0] : r_mask;
            r_ecap <= (r_ecap & ~w_clr) | w_set;
        end
    end

    // Read data refreshed every cycle from the addressed register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rdata <= '0;
        end else begin
            r_rdata <= w_rdata;
        end
    end

    assign readdata = r_rdata;
    assign irq      = |(r_ecap & r_mask);

endmodule

// File: tb/tb_btn_pio_edge.sv
// tb_btn_pio_edge: scoreboard bench running three edge-mode variants against a stability-window model
module tb_btn_pio_edge;
    import btn_pio_pkg::*;

    localparam int W = 2;
    localparam int D = 4;
    localparam int N = 3;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [1:0]    address = '0;
    logic          chipselect = 1'b0;
    logic          write_n = 1'b1;
    logic [31:0]   writedata = '0;
    logic [W-1:0]  in_port = '0;
    logic [31:0]   rd [N];
    logic          irq_o [N];

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    // Instance k uses EDGE_MODE k; instance 2 also idles high
    for (genvar g = 0; g < N; g++) begin : g_dut
        btn_pio_edge #(
            .WIDTH          (W),
            .DEBOUNCE_CYCLES(D),
            .EDGE_MODE      (g),
            .IDLE_LEVEL     ((g == 2) ? 2'b11 : 2'b00)
        ) u_dut (
            .clk       (clk),
            .reset     (reset),
            .address   (address),
            .chipselect(chipselect),
            .write_n   (write_n),
            .writedata (writedata),
            .in_port   (in_port),
            .readdata  (rd[g]),
            .irq       (irq_o[g])
        );
    end

    logic [W-1:0]     m_s1 [N];
    logic [W-1:0]     m_s2 [N];
    logic [W-1:0]     m_db [N];
    logic [W-1:0]     m_mask [N];
    logic [W-1:0]     m_ecap [N];
    logic [W-1:0]     hist [N][D];
    int               hn [N];
    logic [N*32-1:0]  exp_q [$];

    // Reference model: a level is accepted once the last D synchronized samples all disagree with it
    always @(posedge clk) begin
        logic [N*32-1:0] e;
        logic [W-1:0]    idl, nd, rise, fall, set, clr;
        logic            ok;
        e = '0;
        for (int k = 0; k < N; k++) begin
            idl = (k == 2) ? 2'b11 : 2'b00;
            if (reset) begin
                m_s1[k] = idl;
                m_s2[k] = idl;
                m_db[k] = idl;
                m_mask[k] = '0;
                m_ecap[k] = '0;
                hn[k] = 0;
            end else begin
                for (int j = D - 1; j > 0; j--) hist[k][j] = hist[k][j-1];
                hist[k][0] = m_s2[k];
                if (hn[k] < D) hn[k]++;
                nd = m_db[k];
                for (int b = 0; b < W; b++) begin
                    ok = (hn[k] >= D);
                    for (int j = 0; j < D; j++) ok = ok && (hist[k][j][b] != m_db[k][b]);
                    if (ok) nd[b] = ~m_db[k][b];
                end
                rise = nd & ~m_db[k];
                fall = ~nd & m_db[k];
                set = (k == EDGE_RISE) ? rise : (k == EDGE_FALL) ? fall : (rise | fall);
                clr = (chipselect && !write_n && address == ADDR_EDGECAP) ? writedata[W-1:0] : '0;
                e[k*32 +: 32] = (address == ADDR_DATA)    ? {30'b0, m_db[k]}   :
                                (address == ADDR_IRQMASK) ? {30'b0, m_mask[k]} :
                                (address == ADDR_EDGECAP) ? {30'b0, m_ecap[k]} : 32'b0;
                m_ecap[k] = (m_ecap[k] & ~clr) | set;
                if (chipselect && !write_n && address == ADDR_IRQMASK) m_mask[k] = writedata[W-1:0];
                m_db[k] = nd;
                m_s2[k] = m_s1[k];
                m_s1[k] = in_port;
            end
        end
        if (chipselect && write_n) exp_q.push_back(e);
    end

    // Monitor: pop one expected read per completed read cycle, and check irq every cycle
    always @(negedge clk) begin
        logic [N*32-1:0] e;
        logic            want;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            for (int k = 0; k < N; k++) begin
                checks++;
                if (rd[k] !== e[k*32 +: 32]) begin
                    errors++;
                    $display("FAIL readdata dut%0d t=%0t: got %h want %h", k, $time, rd[k], e[k*32 +: 32]);
                end
            end
        end
        for (int k = 0; k < N; k++) begin
            want = |(m_ecap[k] & m_mask[k]);
            checks++;
            if (irq_o[k] !== want) begin
                errors++;
                $display("FAIL irq dut%0d t=%0t: got %b want %b", k, $time, irq_o[k], want);
            end
        end
    end

    task automatic rd_cycles(input logic [1:0] a, input int n);
        address = a;
        chipselect = 1'b1;
        write_n = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        address = a;
        chipselect = 1'b1;
        write_n = 1'b0;
        writedata = d;
        @(negedge clk);
        write_n = 1'b1;
    endtask

    initial begin
        chipselect = 1'b1;
        rd_cycles(ADDR_DATA, 3);
        reset = 1'b0;
        rd_cycles(ADDR_EDGECAP, 2);
        in_port = 2'b01;
        rd_cycles(ADDR_DATA, 9);
        rd_cycles(ADDR_EDGECAP, 2);
        wr(ADDR_DATA, 32'hFFFF_FFFF);
        rd_cycles(ADDR_RSVD, 2);
        wr(ADDR_RSVD, 32'h3);
        wr(ADDR_EDGECAP, 32'h3);
        in_port = 2'b11;
        rd_cycles(ADDR_DATA, 3);
        in_port = 2'b01;
        rd_cycles(ADDR_DATA, 6);
        rd_cycles(ADDR_EDGECAP, 3);
        wr(ADDR_IRQMASK, 32'hFFFF_FFFF);
        rd_cycles(ADDR_IRQMASK, 2);
        in_port = 2'b11;
        rd_cycles(ADDR_EDGECAP, 9);
        wr(ADDR_EDGECAP, 32'h2);
        rd_cycles(ADDR_EDGECAP, 2);
        in_port = 2'b01;
        rd_cycles(ADDR_EDGECAP, 8);
        in_port = 2'b11;
        rd_cycles(ADDR_EDGECAP, 8);
        wr(ADDR_EDGECAP, 32'h1);
        rd_cycles(ADDR_EDGECAP, 2);
        wr(ADDR_IRQMASK, 32'h0);
        wr(ADDR_EDGECAP, 32'h3);
        wr(ADDR_IRQMASK, 32'h3);
        for (int d = 0; d < 8; d++) begin
            in_port = 2'b00;
            rd_cycles(ADDR_DATA, 8);
            wr(ADDR_EDGECAP, 32'h3);
            in_port = 2'b01;
            rd_cycles(ADDR_EDGECAP, d);
            wr(ADDR_EDGECAP, 32'h3);
            rd_cycles(ADDR_EDGECAP, 3);
        end
        in_port = 2'b00;
        rd_cycles(ADDR_DATA, 10);
        wr(ADDR_EDGECAP, 32'h3);
        in_port = 2'b11;
        rd_cycles(ADDR_DATA, 4);
        reset = 1'b1;
        rd_cycles(ADDR_DATA, 2);
        reset = 1'b0;
        rd_cycles(ADDR_IRQMASK, 2);
        rd_cycles(ADDR_EDGECAP, 2);
        rd_cycles(ADDR_DATA, 10);
        rd_cycles(ADDR_EDGECAP, 2);
        for (int c = 0; c < 1500; c++) begin
            if ($urandom_range(0, 5) == 0) in_port = W'($urandom);
            address = 2'($urandom);
            chipselect = ($urandom_range(0, 9) != 0);
            write_n = ($urandom_range(0, 7) != 0);
            writedata = $urandom;
            reset = ($urandom_range(0, 299) == 0);
            @(negedge clk);
        end
        reset = 1'b0;
        rd_cycles(ADDR_DATA, 3);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
